// File: rtl/uart_pkg.sv
// uart_pkg: shared types for uart_tx_fifo (launch FSM states, byte width)
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 2**AW x DATA_W register array, one synchronous write port, async read port
module uart_fifo_mem import uart_pkg::*; #(parameter int AW = 4) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO + launch FSM feeding a UART transmitter, paced on tx_busy
// UART_TX_FIFO_CTS_EN: launches additionally gated on double-flop synchronised cts_n == 0
module uart_tx_fifo import uart_pkg::*; #(parameter int DEPTH_LOG2 = 4) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  we,
  input  logic                  tx_busy,
  output logic                  idle,
  input  logic                  cts_n
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  state_t state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_byte;
  logic push, pop, cts_ok;
`ifdef UART_TX_FIFO_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) cts_sync <= 2'b11;
    else cts_sync <= {cts_sync[0], cts_n};
  assign cts_ok = !cts_sync[1];
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign cts_ok = 1'b1;
`endif
  assign full  = count == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = count == '0;
  assign idle  = empty && state == S_IDLE;
  assign we    = state == S_LAUNCH;
  // a pop in the same cycle frees a slot, so a write at full is still accepted
  assign push  = wr_en && (!full || pop);
  uart_fifo_mem #(.AW(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_byte)
  );
  always_comb begin
    pop = state == S_IDLE && !empty && cts_ok;
    state_nxt = state;
    case (state)
      S_IDLE:      state_nxt = pop ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: state_nxt = tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
      default:     state_nxt = tx_busy ? S_WAIT_DONE : S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + DEPTH_LOG2'(push);
      rd_ptr   <= rd_ptr + DEPTH_LOG2'(pop);
      count    <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      overflow <= (wr_en && !push) || (overflow && !clr_ovf);
      if (pop) tx_data <= rd_byte;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench with a queue-based reference model
module tb_uart_tx_fifo;
  logic clk = 0, resetb = 0, wr_en = 0, clr_ovf = 0, tx_busy = 0, cts_n = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, overflow, we, idle;
  logic [4:0] count;
  logic [7:0] tx_data;
  int passed = 0, total = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_tx = 0;
  bit m_ovf = 0;
  int phase = 0;
`ifdef UART_TX_FIFO_CTS_EN
  bit m_c1 = 1, m_c2 = 1;
`endif
  logic [7:0] emitted[$];
  bit force_busy = 0;
  int bcnt = 0, tx_len = 4;

  uart_tx_fifo dut (
    .clk(clk), .resetb(resetb), .wr_data(wr_data), .wr_en(wr_en), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf), .tx_data(tx_data), .we(we),
    .tx_busy(tx_busy), .idle(idle), .cts_n(cts_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int n, input string nm);
    for (int i = 0; i < n && !idle; i++) step(1);
    chk(nm, idle, 1);
  endtask

  task automatic wait_emitted(input int want, input int n, input string nm);
    for (int i = 0; i < n && emitted.size() < want; i++) step(1);
    chk(nm, emitted.size(), want);
  endtask

  // phase: 0 nothing in flight, 1 strobe cycle, 2 awaiting busy, 3 awaiting release
  always @(posedge clk or negedge resetb)
    if (!resetb) begin
      m_q.delete(); m_tx = 0; m_ovf = 0; phase = 0;
`ifdef UART_TX_FIFO_CTS_EN
      m_c1 = 1; m_c2 = 1;
`endif
    end else begin : mdl
      bit ok;
      bit ovf_now;
      ok = 1;
`ifdef UART_TX_FIFO_CTS_EN
      ok = !m_c2; m_c2 = m_c1; m_c1 = cts_n;
`endif
      if (phase == 0 && m_q.size() > 0 && ok) begin m_tx = m_q.pop_front(); phase = 1; end
      else if (phase == 1) phase = 2;
      else if (phase == 2 && tx_busy) phase = 3;
      else if (phase == 3 && !tx_busy) phase = 0;
      ovf_now = wr_en && m_q.size() == 16;
      if (wr_en && !ovf_now) m_q.push_back(wr_data);
      m_ovf = ovf_now || (m_ovf && !clr_ovf);
    end

  always @(negedge clk) begin
    chk("count", int'(count), m_q.size());
    chk("full", full, int'(m_q.size() == 16));
    chk("empty", empty, int'(m_q.size() == 0));
    chk("overflow", overflow, m_ovf);
    chk("we", we, int'(phase == 1));
    chk("tx_data", tx_data, m_tx);
    chk("idle", idle, int'(m_q.size() == 0 && phase == 0));
    if (we) emitted.push_back(tx_data);
  end

  // transmitter stand-in: busy for tx_len cycles after each strobe, or held by force_busy
  initial forever begin
    @(negedge clk);
    if (we) bcnt = tx_len;
    else if (bcnt > 0) bcnt--;
    tx_busy = force_busy || bcnt > 0;
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_idle", idle, 1);
    chk("rst_count", count, 0);
    resetb = 1;
    step(3);
    // single byte latency and idle return
    tx_len = 10; wr_data = 8'hA5; wr_en = 1; step(1); wr_en = 0;
    @(negedge clk); chk("t1_we_early", we, 0);
    @(negedge clk); chk("t1_we", we, 1); chk("t1_data", tx_data, 8'hA5); chk("t1_not_idle", idle, 0);
    @(negedge clk); chk("t1_we_pulse", we, 0);
    wait_idle(40, "t1_idle");
    // park the FSM on a dummy byte so 16 bytes can fill the FIFO
    tx_len = 4; force_busy = 1; wr_data = 8'hEE; wr_en = 1; step(1); wr_en = 0; step(6);
    emitted.delete();
    for (int i = 0; i < 16; i++) begin wr_data = 8'(i); wr_en = 1; step(1); end
    wr_en = 0;
    @(negedge clk); chk("t2_full", full, 1); chk("t2_count", count, 16); chk("t2_ovf0", overflow, 0);
    step(1); wr_data = 8'hFF; wr_en = 1; step(1); wr_en = 0;
    @(negedge clk); chk("t2_ovf", overflow, 1); chk("t2_count_kept", count, 16);
    step(1); wr_en = 1; clr_ovf = 1; step(1); wr_en = 0; clr_ovf = 0;
    @(negedge clk); chk("t6_set_wins", overflow, 1);
    step(1); clr_ovf = 1; step(1); clr_ovf = 0;
    @(negedge clk); chk("t6_clear", overflow, 0);
    // release busy: FSM idles next edge, pops the edge after, coincident with this write
    step(1); force_busy = 0; step(1); wr_data = 8'h10; wr_en = 1; step(1); wr_en = 0;
    @(negedge clk); chk("t3_count", count, 16); chk("t3_ovf", overflow, 0); chk("t3_we", we, 1);
    step(1);
    wait_emitted(17, 400, "t2_pulses");
    for (int i = 0; i < emitted.size(); i++) chk("t2_order", emitted[i], i);
    wait_idle(40, "t2_idle");
    // reset while waiting on the transmitter with 5 bytes queued
    force_busy = 1; wr_data = 8'h55; wr_en = 1; step(1); wr_en = 0; step(5);
    for (int i = 0; i < 5; i++) begin wr_data = 8'h60 + 8'(i); wr_en = 1; step(1); end
    wr_en = 0; step(2);
    chk("t4_pre_count", count, 5); chk("t4_pre_idle", idle, 0);
    resetb = 0;
    @(negedge clk);
    chk("t4_full", full, 0); chk("t4_empty", empty, 1); chk("t4_count", count, 0);
    chk("t4_ovf", overflow, 0); chk("t4_tx", tx_data, 0); chk("t4_we", we, 0); chk("t4_idle", idle, 1);
    step(1); resetb = 1; force_busy = 0; emitted.delete(); step(20);
    chk("t4_no_we", emitted.size(), 0);
`ifdef UART_TX_FIFO_CTS_EN
    begin : cts_test
      int k;
      cts_n = 1; step(3);
      for (int i = 0; i < 3; i++) begin wr_data = 8'h31 + 8'(i); wr_en = 1; step(1); end
      wr_en = 0; step(10);
      chk("t5_held", emitted.size(), 0); chk("t5_count", count, 3);
      cts_n = 0; k = 0;
      while (emitted.size() == 0 && k < 5) begin step(1); k++; end
      chk("t5_first_we", int'(k <= 4 && emitted.size() == 1), 1);
      cts_n = 1; step(30);
      chk("t5_one_only", emitted.size(), 1);
      cts_n = 0;
      wait_emitted(3, 80, "t5_rest");
      for (int i = 0; i < emitted.size(); i++) chk("t5_order", emitted[i], 8'h31 + i);
    end
`endif
    for (int c = 0; c < 1200; c++) begin
      wr_en = $urandom_range(0, 2) == 0;
      wr_data = 8'($urandom);
      clr_ovf = $urandom_range(0, 19) == 0;
      tx_len = $urandom_range(2, 6);
      if ($urandom_range(0, 39) == 0) force_busy = !force_busy;
`ifdef UART_TX_FIFO_CTS_EN
      if ($urandom_range(0, 29) == 0) cts_n = !cts_n;
`endif
      step(1);
    end
    wr_en = 0; clr_ovf = 0; force_busy = 0; cts_n = 0;
    wait_idle(600, "drain_idle");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
